// File: rtl/mem_copy_engine.sv
// mem_copy_engine: copies a block of words within one port of a dual-port
// memory. Each word is read from the source, then written to the destination.
// Each word takes one READ cycle and one WRITE cycle.
//
// Optional feature: define MEM_COPY_CHECKSUM_EN to add the checksum output.
// The checksum is the modulo-2^DATA_W sum of the words written by the most
// recently accepted transfer.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        request pulse, sampled only while idle
//   src_address  first source word address (latched on accepted start)
//   dst_address  first destination word address (latched on accepted start)
//   length       word count (latched on accepted start)
//   mem_address  memory port address
//   mem_in       memory port write data
//   mem_we       memory port write enable
//   mem_out      memory port registered read data (one cycle after address)
//   busy         high while a transfer is in progress
//   done         one-cycle completion pulse
//   checksum     sum of written words (only with MEM_COPY_CHECKSUM_EN)
module mem_copy_engine #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_address,
  input  logic [ADDR_W-1:0] dst_address,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_out,
  output logic              busy,
  output logic              done
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              mem_we_q, mem_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

  // Next-state logic. Registered outputs are computed for the state being
  // entered, so they line up with the state register.
  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dst_d         = dst_q;
    cnt_d         = cnt_q;
    mem_address_d = '0;
    mem_we_d      = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
    checksum_d    = checksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MEM_COPY_CHECKSUM_EN
          checksum_d = '0;
`endif
          busy_d = 1'b1;
          if (length != '0) begin
            src_d         = src_address;
            dst_d         = dst_address;
            cnt_d         = length;
            mem_address_d = src_address;
            state_d       = READ;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      READ: begin
        busy_d        = 1'b1;
        mem_address_d = dst_q;
        mem_we_d      = 1'b1;
        state_d       = WRITE;
      end
      WRITE: begin
        busy_d = 1'b1;
        src_d  = src_q + ADDR_W'(1);
        dst_d  = dst_q + ADDR_W'(1);
        cnt_d  = cnt_q - ADDR_W'(1);
`ifdef MEM_COPY_CHECKSUM_EN
        checksum_d = checksum_q + mem_out;
`endif
        // Decide on the count before the decrement: one word left means last.
        if (cnt_q != ADDR_W'(1)) begin
          mem_address_d = src_q + ADDR_W'(1);
          state_d       = READ;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      src_q         <= '0;
      dst_q         <= '0;
      cnt_q         <= '0;
      mem_address_q <= '0;
      mem_we_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      cnt_q         <= cnt_d;
      mem_address_q <= mem_address_d;
      mem_we_q      <= mem_we_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef MEM_COPY_CHECKSUM_EN
      checksum_q    <= checksum_d;
`endif
    end
  end

  assign mem_address = mem_address_q;
  assign mem_we      = mem_we_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef MEM_COPY_CHECKSUM_EN
  assign checksum    = checksum_q;
`endif

  // Read data only becomes valid in the WRITE cycle, so the write data is a
  // gated pass-through of mem_out. It cannot be registered without adding a
  // cycle per word. The gating forces it to zero in all other states,
  // including during reset.
  assign mem_in = (state_q == WRITE) ? mem_out : '0;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine. It uses table-driven and random
// transfers, compared against a word-by-word reference copy of the memory.
module tb_mem_copy_engine;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] src_address, dst_address, length;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_in, mem_out;
  logic              mem_we, busy, done;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  mem_copy_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_address(src_address), .dst_address(dst_address), .length(length),
    .mem_address(mem_address), .mem_in(mem_in), .mem_we(mem_we),
    .mem_out(mem_out), .busy(busy), .done(done)
`ifdef MEM_COPY_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  // Memory port: registered read data, plus a bench-side preload port.
  logic [DATA_W-1:0] mem [DEPTH];
  logic              init_req, tb_we;
  logic [ADDR_W-1:0] tb_addr;
  logic [DATA_W-1:0] tb_data;

  function automatic logic [DATA_W-1:0] init_word(int i);
    return 16'(i * 40503 + 4660);
  endfunction

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= init_word(i);
    end else if (tb_we) begin
      mem[tb_addr] <= tb_data;
    end else if (mem_we) begin
      mem[mem_address] <= mem_in;
    end
    mem_out <= mem[mem_address];
  end

  // Write and done monitor.
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  wr_t wq[$];
  int  done_total = 0;

  always @(posedge clk) begin
    if (mem_we) wq.push_back({mem_address, mem_in});
    if (done) done_total++;
  end

  // Reference memory image.
  logic [DATA_W-1:0] ref_mem [DEPTH];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(bit ok, string name, longint act, longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  task automatic mem_image_check(input string tag);
    int mism = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== ref_mem[i]) mism++;
    chk(mism == 0, {tag, "/mem_image_mismatches"}, mism, 0);
  endtask

  task automatic preset(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_data = v;
    @(negedge clk);
    tb_we = 1'b0;
    ref_mem[a] = v;
  endtask

  // One transfer. Releasing reset on the same negedge as start checks that
  // the first edge after reset can accept a request.
  task automatic run_copy(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] d,
                          input logic [ADDR_W-1:0] l, input int inject,
                          input int exp_busy, input int exp_done, input string tag);
    int busy_cnt = 0, done_cnt = 0, done_at = 0, seq_mism = 0;
    bit idle_ok = 1'b1, ended = 1'b0;
    wr_t exp_q[$];
    logic [DATA_W-1:0] sum = '0;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < int'(l); i++) begin
      a = d + ADDR_W'(i);
      ref_mem[a] = ref_mem[ADDR_W'(s + ADDR_W'(i))];
      exp_q.push_back({a, ref_mem[a]});
      sum += ref_mem[a];
    end
    @(negedge clk);
    src_address = s; dst_address = d; length = l; start = 1'b1; reset = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    src_address = ADDR_W'($urandom); dst_address = ADDR_W'($urandom);
    length = ADDR_W'($urandom);
    wq.delete();
    for (int k = 1; k <= 2 * int'(l) + 20; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = k;
        if (mem_we || mem_address != '0 || mem_in != '0) idle_ok = 1'b0;
      end
      if (!busy) begin
        if (mem_we || done || mem_address != '0 || mem_in != '0) idle_ok = 1'b0;
        ended = 1'b1;
        start = 1'b0;
        break;
      end
      if (k == inject) begin
        start = 1'b1;
        src_address = ADDR_W'($urandom); dst_address = ADDR_W'($urandom);
        length = ADDR_W'($urandom_range(1, 8));
      end else begin
        start = 1'b0;
      end
    end
    chk(ended, {tag, "/completed_in_budget"}, ended, 1);
    chk(busy_cnt == exp_busy, {tag, "/busy_cycles"}, busy_cnt, exp_busy);
    chk(done_cnt == 1, {tag, "/done_pulses"}, done_cnt, 1);
    chk(done_at == exp_done, {tag, "/done_cycle"}, done_at, exp_done);
    chk(wq.size() == exp_q.size(), {tag, "/write_count"}, wq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
      if (wq[i] !== exp_q[i]) seq_mism++;
    chk(seq_mism == 0, {tag, "/write_sequence_mismatches"}, seq_mism, 0);
    chk(idle_ok, {tag, "/idle_and_done_outputs_zero"}, idle_ok, 1);
`ifdef MEM_COPY_CHECKSUM_EN
    chk(checksum == sum, {tag, "/checksum"}, checksum, sum);
`endif
    mem_image_check(tag);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] len;
    int                inject;
    int                exp_busy;
    int                exp_done;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{15'h0010, 15'h0100, 15'd4, 0, 9, 9};
    tbl[1] = '{15'h0000, 15'h0000, 15'd0, 0, 1, 1};
    tbl[2] = '{15'h7FFE, 15'h7FFF, 15'd2, 0, 5, 5};
    tbl[3] = '{15'h0040, 15'h0400, 15'd6, 3, 13, 13};
    tbl[4] = '{15'h1234, 15'h1236, 15'd5, 0, 11, 11};
    tbl[5] = '{15'h3000, 15'h2FFE, 15'd3, 0, 7, 7};
    tbl[6] = '{15'h7FFF, 15'h5000, 15'd3, 4, 7, 7};

    reset = 1'b1; start = 1'b0; init_req = 1'b1; tb_we = 1'b0;
    tb_addr = '0; tb_data = '0;
    src_address = '0; dst_address = '0; length = '0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    init_req = 1'b0;

    chk({busy, done, mem_we} == 3'b000, "reset/busy_done_we", {busy, done, mem_we}, 0);
    chk(mem_address == '0, "reset/mem_address", mem_address, 0);
    chk(mem_in == '0, "reset/mem_in", mem_in, 0);
`ifdef MEM_COPY_CHECKSUM_EN
    chk(checksum == '0, "reset/checksum", checksum, 0);
`endif

    preset(15'h0010, 16'h1111);
    preset(15'h0011, 16'h2222);
    preset(15'h0012, 16'h3333);
    preset(15'h0013, 16'h4444);
    preset(15'h7FFE, 16'hBEEF);
    preset(15'h7FFF, 16'hCAFE);
    mem_image_check("preload");

    // The first entry starts while reset is still asserted.
    for (int t = 0; t < 7; t++)
      run_copy(tbl[t].src, tbl[t].dst, tbl[t].len, tbl[t].inject,
               tbl[t].exp_busy, tbl[t].exp_done, $sformatf("vec%0d", t));
    chk(ref_mem[15'h0000] == 16'hBEEF, "wrap/ref_word0", ref_mem[15'h0000], 16'hBEEF);

    // Reset applied between edges during the write of word 2 of 4.
    begin
      int d0;
      @(negedge clk);
      src_address = 15'h0020; dst_address = 15'h0200; length = 15'd4; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wq.delete();
      d0 = done_total;
      repeat (3) @(posedge clk);
      #3;
      chk(mem_we && mem_address == 15'h0201, "rst_mid/in_write2",
          {mem_we, mem_address}, {1'b1, 15'h0201});
      reset = 1'b1;
      #1;
      chk({busy, done, mem_we} == 3'b000, "rst_mid/busy_done_we", {busy, done, mem_we}, 0);
      chk(mem_address == '0 && mem_in == '0, "rst_mid/addr_data",
          {mem_address, mem_in}, 0);
`ifdef MEM_COPY_CHECKSUM_EN
      chk(checksum == '0, "rst_mid/checksum", checksum, 0);
`endif
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      ref_mem[15'h0200] = ref_mem[15'h0020];
      chk(wq.size() == 1, "rst_mid/write_count", wq.size(), 1);
      if (wq.size() > 0)
        chk(wq[0] == {15'h0200, ref_mem[15'h0020]}, "rst_mid/first_write",
            wq[0], {15'h0200, ref_mem[15'h0020]});
      chk(done_total == d0, "rst_mid/no_done", done_total - d0, 0);
      mem_image_check("rst_mid");
    end

    run_copy(15'h0020, 15'h0200, 15'd4, 0, 9, 9, "after_rst");

    for (int r = 0; r < 10; r++) begin
      logic [ADDR_W-1:0] rs, rd, rl;
      int inj;
      rs  = ADDR_W'($urandom);
      rd  = ADDR_W'($urandom);
      rl  = ADDR_W'($urandom_range(1, 24));
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 2 * int'(rl))) : 0;
      run_copy(rs, rd, rl, inj, 2 * int'(rl) + 1, 2 * int'(rl) + 1, $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
